// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the shift-and-add multiply sequencer.
// Includes the ALU control codes and the sequencer FSM state encoding.
package mul_sequencer_pkg;

  localparam int unsigned ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND   = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR    = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_PASSB = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_sequencer.sv
// Sequential shift-and-add multiplier that borrows an external ALU for its additions.
// Returns the low n bits of op_a*op_b; early exit once the remaining multiplier bits are zero.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int unsigned n = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [n-1:0]          op_a,
  input  logic [n-1:0]          op_b,
  output logic [n-1:0]          alu_a,
  output logic [n-1:0]          alu_b,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  input  logic [n-1:0]          alu_out,
  output logic                  busy,
  output logic                  done,
  output logic [n-1:0]          result,
  output logic                  res_zero
);

  localparam int unsigned CntW = $clog2(n);

  state_e          state_q, state_d;
  logic [n-1:0]    acc_q, acc_d;
  logic [n-1:0]    mcand_q, mcand_d;
  logic [n-1:0]    mplier_q, mplier_d;
  logic [CntW-1:0] count_q, count_d;
  logic [n-1:0]    result_q, result_d;
  logic            res_zero_q, res_zero_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Next-state, datapath updates and combinational ALU drive
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    count_d    = count_q;
    result_d   = result_q;
    res_zero_d = res_zero_q;
    alu_a      = '0;
    alu_b      = '0;
    alu_ctrl   = ALU_AND;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          count_d  = '0;
          state_d  = (op_b != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        alu_a    = acc_q;
        alu_b    = mplier_q[0] ? mcand_q : '0;
        alu_ctrl = ALU_ADD;
        if (abort) begin
          state_d = IDLE;
        end else begin
          acc_d    = alu_out;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CntW'(1);
          if ((mplier_d == '0) || (count_q == CntW'(n - 1))) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Result registers update only on entry to DONE, so they hold across aborts
    if ((state_d == DONE) && (state_q != DONE)) begin
      result_d   = acc_d;
      res_zero_d = (acc_d == '0);
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      count_q    <= '0;
      result_q   <= '0;
      res_zero_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      count_q    <= count_d;
      result_q   <= result_d;
      res_zero_q <= res_zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign res_zero = res_zero_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed self-checking bench for mul_sequencer with a behavioural ALU model.
module tb_mul_sequencer;

  localparam int unsigned N = 64;
  localparam int unsigned MAX_WAIT = 200;

  logic         clk;
  logic         rst;
  logic         start;
  logic         abort;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [3:0]   alu_ctrl;
  logic [N-1:0] alu_out;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         res_zero;

  int n_checks = 0;
  int n_fail   = 0;

  mul_sequencer #(.n(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .op_a     (op_a),
    .op_b     (op_b),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_ctrl (alu_ctrl),
    .alu_out  (alu_out),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .res_zero (res_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b0010: alu_out = alu_a + alu_b;
      4'b0110: alu_out = alu_a - alu_b;
      4'b0111: alu_out = alu_b;
      4'b1100: alu_out = ~(alu_a | alu_b);
      default: alu_out = '0;
    endcase
  end

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] res;
    int           lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT back in IDLE.
  task automatic do_mul(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] exp_res, input int exp_lat);
    int lat;
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(negedge clk);
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    lat   = 1;
    while (!done && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " done seen"}, N'(done), N'(1));
    chk({tag, " latency"}, N'(lat), N'(exp_lat));
    chk({tag, " result"}, result, exp_res);
    chk({tag, " res_zero"}, N'(res_zero), N'(exp_res == '0));
    chk({tag, " busy at done"}, N'(busy), N'(0));
    @(negedge clk);
    chk({tag, " done one cycle"}, N'(done), N'(0));
    chk({tag, " result held"}, result, exp_res);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    op_a  = '0;
    op_b  = '0;

    vecs[0] = '{a: 64'd7,     b: 64'd6,                  res: 64'd42,                  lat: 4};
    vecs[1] = '{a: 64'd123,   b: 64'd0,                  res: 64'd0,                   lat: 1};
    vecs[2] = '{a: 64'd1,     b: 64'h8000_0000_0000_0000, res: 64'h8000_0000_0000_0000, lat: 65};
    vecs[3] = '{a: 64'd2,     b: 64'h8000_0000_0000_0000, res: 64'd0,                   lat: 65};
    vecs[4] = '{a: 64'hFFFF_FFFF_FFFF_FFFD, b: 64'd5,    res: 64'hFFFF_FFFF_FFFF_FFF1, lat: 4};
    vecs[5] = '{a: 64'd0,     b: 64'hFF,                 res: 64'd0,                   lat: 9};
    vecs[6] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF, res: 64'd1,    lat: 65};
    vecs[7] = '{a: 64'd12345, b: 64'd1,                  res: 64'd12345,               lat: 2};
    vecs[8] = '{a: 64'h1_0000_0001, b: 64'd3,            res: 64'h3_0000_0003,         lat: 3};

    #2;
    chk("reset busy", N'(busy), N'(0));
    chk("reset done", N'(done), N'(0));
    chk("reset result", result, '0);
    chk("reset res_zero", N'(res_zero), N'(1));
    chk("reset alu_ctrl", N'(alu_ctrl), N'(0));
    chk("reset alu_b", alu_b, '0);

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
    end

    // ALU drive during RUN: 7*6 -> cycle T+1 adds 0, cycle T+2 adds 14
    start = 1'b1; op_a = 64'd7; op_b = 64'd6;
    @(negedge clk);
    start = 1'b0;
    chk("run busy", N'(busy), N'(1));
    chk("run alu_ctrl", N'(alu_ctrl), N'(4'b0010));
    chk("run c1 alu_a", alu_a, 64'd0);
    chk("run c1 alu_b", alu_b, 64'd0);
    @(negedge clk);
    chk("run c2 alu_a", alu_a, 64'd0);
    chk("run c2 alu_b", alu_b, 64'd14);
    @(negedge clk);
    chk("run c3 alu_a", alu_a, 64'd14);
    chk("run c3 alu_b", alu_b, 64'd28);
    @(negedge clk);
    chk("run done", N'(done), N'(1));
    chk("run result", result, 64'd42);
    chk("done alu_ctrl", N'(alu_ctrl), N'(0));
    @(negedge clk);

    // Abort at T+3 of a 0xFF multiply: no done, result keeps 42
    start = 1'b1; op_a = 64'd5; op_b = 64'hFF;
    @(negedge clk);
    start = 1'b0;
    chk("abort T+1 busy", N'(busy), N'(1));
    @(negedge clk);
    chk("abort T+2 done", N'(done), N'(0));
    @(negedge clk);
    abort = 1'b1;
    chk("abort T+3 busy", N'(busy), N'(1));
    @(negedge clk);
    abort = 1'b0;
    chk("abort T+4 busy", N'(busy), N'(0));
    chk("abort T+4 done", N'(done), N'(0));
    chk("abort result kept", result, 64'd42);
    chk("abort res_zero kept", N'(res_zero), N'(0));
    do_mul("after abort", 64'd3, 64'd4, 64'd12, 4);

    // Abort in IDLE is harmless; start pulsed while busy is ignored
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle abort busy", N'(busy), N'(0));
    start = 1'b1; op_a = 64'd3; op_b = 64'h10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op_a = 64'd100; op_b = 64'd1;
    @(negedge clk);
    start = 1'b0; op_a = '0; op_b = '0;
    begin
      int lat;
      lat = 3;
      while (!done && lat < MAX_WAIT) begin
        @(negedge clk);
        lat++;
      end
      chk("ignored start latency", N'(lat), N'(6));
      chk("ignored start result", result, 64'd48);
    end
    @(negedge clk);
    @(negedge clk);
    chk("no queued op busy", N'(busy), N'(0));
    chk("no queued op done", N'(done), N'(0));

    // Reset mid-RUN takes effect without a clock edge
    start = 1'b1; op_a = 64'd1; op_b = 64'hFFFF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset busy", N'(busy), N'(1));
    rst = 1'b1;
    #1;
    chk("async reset busy", N'(busy), N'(0));
    chk("async reset done", N'(done), N'(0));
    chk("async reset result", result, '0);
    chk("async reset res_zero", N'(res_zero), N'(1));
    chk("async reset alu_ctrl", N'(alu_ctrl), N'(0));
    @(negedge clk);
    rst = 1'b0;
    do_mul("post reset", 64'd7, 64'd6, 64'd42, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have parameter n, default 64: operand and result width.
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1: request a multiply, sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1: cancel an in-flight multiply.
REQ-006 SHALL have port op_a, input, n: multiplicand, captured on the start cycle.
REQ-007 SHALL have port op_b, input, n: multiplier, captured on the start cycle.
REQ-008 SHALL have port alu_a, output, n: A operand to the shared ALU.
REQ-009 SHALL have port alu_b, output, n: B operand to the shared ALU.
REQ-010 SHALL have port alu_ctrl, output, 4: ALU control code.
REQ-011 SHALL have port alu_out, input, n: ALU result, combinational, valid within the same cycle.
REQ-012 SHALL have port busy, output, 1: high in RUN.
REQ-013 SHALL have port done, output, 1: one-cycle pulse, result valid.
REQ-014 SHALL have port result, output, n: low n bits of op_a*op_b, unsigned/two's-complement modulo 2^n.
REQ-015 SHALL have port res_zero, output, 1: result == 0.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered except alu_a/alu_b/alu_ctrl.
REQ-017 IDLE with start=1 SHALL load acc=0, mcand=op_a, mplier=op_b, count=0; go to RUN if op_b!=0, else DONE.
REQ-018 RUN SHALL drive alu_a=acc, alu_b=(mplier[0] ? mcand : 0), alu_ctrl=4'b0010 (ADD).
REQ-019 Each RUN cycle SHALL update acc<=alu_out, mcand<=mcand<<1, mplier<=mplier>>1 (zero-fill), count<=count+1; carries beyond bit n-1 discarded.
REQ-020 RUN SHALL exit to DONE when the shifted mplier is zero or count reaches n-1; otherwise it stays in RUN.
REQ-021 Latency: start at cycle T; done=1 at T+k+1, k = bit position of op_b's highest set bit +1 (k=0 for op_b=0); maximum n+1 cycles.
REQ-022 DONE SHALL last exactly one cycle with done=1, result=acc, res_zero=(acc==0), then return to IDLE.
REQ-023 result and res_zero SHALL hold their value until the next DONE; done=0 outside DONE.
REQ-024 start while in RUN or DONE SHALL be ignored; no queueing.
REQ-025 abort=1 in RUN SHALL force IDLE on the next edge with no done pulse, and result SHALL stay unchanged; abort in IDLE/DONE has no effect; abort has priority over start in the same cycle.
REQ-026 Outside RUN, alu_a=0, alu_b=0, alu_ctrl=4'b0000 (AND), giving a zero ALU result.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, busy=0, done=0, result=0, res_zero=1, acc=mcand=mplier=0, count=0.
REQ-028 Reset mid-RUN SHALL discard the operation without a done pulse; start SHALL be honoured on the first edge after rst deasserts.

Structure
REQ-029 ALU control codes (AND 0000, OR 0001, ADD 0010, SUB 0110, PASSB 0111, NOR 1100) and the FSM state encoding SHALL live in a shared package.
REQ-030 The ALU SHALL be external, connected through alu_* ports; the only sub-module SHALL be none (the FSM and shift registers are flat in mul_sequencer).
REQ-031 count SHALL be $clog2(n) bits wide.

Verification
REQ-032 The bench SHALL cover op_a=7, op_b=6 -> done at T+4, result=42, res_zero=0.
REQ-033 The bench SHALL cover op_a=123, op_b=0 -> done at T+1, result=0, res_zero=1, no RUN cycle.
REQ-034 The bench SHALL cover op_a=1, op_b=2^63 (n=64) -> done at T+65, result=2^63; then op_a=2, op_b=2^63 -> result=0, res_zero=1.
REQ-035 The bench SHALL cover op_a=-3 (all-ones-minus-2), op_b=5 -> result=-15 modulo 2^64.
REQ-036 The bench SHALL cover start at T with op_b=0xFF, abort at T+3 -> busy=0 at T+4, no done, result keeps its previous value; a new start at T+4 completes normally.
REQ-037 The bench SHALL cover rst asserted mid-RUN -> outputs reach reset values without a clock edge, and a start pulsed while busy is ignored.
